// File: rtl/disc_frame_loader_if.sv
// Sample-stream and result handshake bundle for the discriminator frame loader.
interface disc_frame_loader_if #(
   parameter int WIDTH = 32
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_score;
   logic             m_real;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_score, m_real
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_score, m_real
   );
endinterface

// File: rtl/disc_frame_loader.sv
// Packs 9 serial samples into a_1..a_9, holds them SETTLE_CYC cycles, then captures/thresholds y.
// m_valid rises SETTLE_CYC edges after the 9th beat; result is held under m_ready=0 and no sample is taken until it drains.
module disc_frame_loader #(
   parameter int WIDTH      = 32,
   parameter int N_INPUT    = 9,
   parameter int SETTLE_CYC = 2,
   parameter int THRESH     = 0
) (
   input  logic               clk,
   input  logic               rst,
   disc_frame_loader_if.slave bus,
   output logic [WIDTH-1:0]   a_1,
   output logic [WIDTH-1:0]   a_2,
   output logic [WIDTH-1:0]   a_3,
   output logic [WIDTH-1:0]   a_4,
   output logic [WIDTH-1:0]   a_5,
   output logic [WIDTH-1:0]   a_6,
   output logic [WIDTH-1:0]   a_7,
   output logic [WIDTH-1:0]   a_8,
   output logic [WIDTH-1:0]   a_9,
   output logic               frame_vld,
   input  logic [WIDTH-1:0]   y,
   output logic               err_short
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [3:0] LAST_CNT = 4'(N_INPUT - 1);
   localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYC - 1);
   localparam logic signed [WIDTH-1:0] THR = WIDTH'(THRESH);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [SW-1:0]    scnt;
   logic [WIDTH-1:0] frame [N_INPUT];
   logic             m_valid_r;
   logic [WIDTH-1:0] m_score_r;
   logic             m_real_r;
   logic             s_ready_c;
   logic             beat;

   assign s_ready_c   = (state == LOAD) && !rst;
   assign beat        = bus.s_valid && s_ready_c;
   assign bus.s_ready = s_ready_c;
   assign bus.m_valid = m_valid_r;
   assign bus.m_score = m_score_r;
   assign bus.m_real  = m_real_r;

   assign a_1 = frame[0];
   assign a_2 = frame[1];
   assign a_3 = frame[2];
   assign a_4 = frame[3];
   assign a_5 = frame[4];
   assign a_6 = frame[5];
   assign a_7 = frame[6];
   assign a_8 = frame[7];
   assign a_9 = frame[8];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         cnt       <= '0;
         scnt      <= '0;
         for (int i = 0; i < N_INPUT; i++) frame[i] <= '0;
         frame_vld <= 1'b0;
         m_valid_r <= 1'b0;
         m_score_r <= '0;
         m_real_r  <= 1'b0;
         err_short <= 1'b0;
      end else begin
         err_short <= 1'b0;
         case (state)
            LOAD: begin
               if (beat) begin
                  for (int i = 0; i < N_INPUT; i++)
                     if (cnt == 4'(i)) frame[i] <= bus.s_data;
                  // On the 9th sample s_last is a don't-care; a short frame keeps its partial a_* contents.
                  if (cnt == LAST_CNT) begin
                     state     <= SETTLE;
                     frame_vld <= 1'b1;
                     cnt       <= '0;
                     scnt      <= '0;
                  end else if (bus.s_last) begin
                     cnt       <= '0;
                     err_short <= 1'b1;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            SETTLE: begin
               if (scnt == LAST_SETTLE) begin
                  m_score_r <= y;
                  m_real_r  <= ($signed(y) >= THR);
                  m_valid_r <= 1'b1;
                  state     <= OUT;
               end else begin
                  scnt <= scnt + 1'b1;
               end
            end
            OUT: begin
               if (bus.m_ready) begin
                  m_valid_r <= 1'b0;
                  frame_vld <= 1'b0;
                  state     <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_disc_frame_loader.sv
// Directed bench for disc_frame_loader; y is modelled as sum(a_*) or a forced constant.
module tb_disc_frame_loader;
   localparam int WIDTH      = 32;
   localparam int SETTLE_CYC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   disc_frame_loader_if #(.WIDTH(WIDTH)) bus ();

   logic [WIDTH-1:0] a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8, a_9;
   logic             frame_vld;
   logic             err_short;
   logic [WIDTH-1:0] y;
   logic             ymode;
   logic [WIDTH-1:0] yconst;
   logic [WIDTH-1:0] a_arr [9];

   int vectors     = 0;
   int miscompares = 0;

   always_comb begin
      y = ymode ? yconst : (a_1 + a_2 + a_3 + a_4 + a_5 + a_6 + a_7 + a_8 + a_9);
   end

   assign a_arr[0] = a_1;
   assign a_arr[1] = a_2;
   assign a_arr[2] = a_3;
   assign a_arr[3] = a_4;
   assign a_arr[4] = a_5;
   assign a_arr[5] = a_6;
   assign a_arr[6] = a_7;
   assign a_arr[7] = a_8;
   assign a_arr[8] = a_9;

   disc_frame_loader #(
      .WIDTH(WIDTH), .N_INPUT(9), .SETTLE_CYC(SETTLE_CYC), .THRESH(0)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .a_1(a_1), .a_2(a_2), .a_3(a_3), .a_4(a_4), .a_5(a_5),
      .a_6(a_6), .a_7(a_7), .a_8(a_8), .a_9(a_9),
      .frame_vld(frame_vld), .y(y), .err_short(err_short)
   );

   task automatic beat(input int d, input logic l);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(d);
      bus.s_last  = l;
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic send_frame(input int start);
      for (int i = 0; i < 9; i++) beat(start + i, (i == 8));
   endtask

   task automatic wait_result(output int n);
      n = 0;
      while (bus.m_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic handshake();
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
      vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
      vectors++; if (frame_vld !== 1'b0) begin miscompares++; $display("FAIL reset_frame_vld: got %b want 0", frame_vld); end
      vectors++; if (err_short !== 1'b0) begin miscompares++; $display("FAIL reset_err_short: got %b want 0", err_short); end
      vectors++; if (bus.m_score !== 32'd0 || bus.m_real !== 1'b0) begin miscompares++; $display("FAIL reset_result: got %0d/%b want 0/0", bus.m_score, bus.m_real); end
      for (int i = 0; i < 9; i++) begin
         vectors++; if (a_arr[i] !== 32'd0) begin miscompares++; $display("FAIL reset_a_%0d: got %0d want 0", i + 1, a_arr[i]); end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_s_ready: got %b want 1", bus.s_ready); end
   endtask

   task automatic test_basic_frame();
      int n;
      ymode = 1'b0;
      send_frame(1);
      vectors++; if (frame_vld !== 1'b1) begin miscompares++; $display("FAIL basic_frame_vld: got %b want 1", frame_vld); end
      vectors++; if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL basic_s_ready_settle: got %b want 0", bus.s_ready); end
      wait_result(n);
      // negedges T+0.5, T+1.5, T+2.5: m_valid first seen on the third
      vectors++; if (n !== SETTLE_CYC + 1) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", n, SETTLE_CYC + 1); end
      vectors++; if (bus.m_score !== 32'd45) begin miscompares++; $display("FAIL basic_score: got %0d want 45", $signed(bus.m_score)); end
      vectors++; if (bus.m_real !== 1'b1) begin miscompares++; $display("FAIL basic_real: got %b want 1", bus.m_real); end
      for (int i = 0; i < 9; i++) begin
         vectors++; if (a_arr[i] !== 32'(i + 1)) begin miscompares++; $display("FAIL basic_a_%0d: got %0d want %0d", i + 1, a_arr[i], i + 1); end
      end
      handshake();
      vectors++; if (bus.m_valid !== 1'b0 || frame_vld !== 1'b0) begin miscompares++; $display("FAIL basic_drain: got %b/%b want 0/0", bus.m_valid, frame_vld); end
      vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL basic_back_to_load: got %b want 1", bus.s_ready); end
   endtask

   task automatic test_threshold();
      int n;
      logic [WIDTH-1:0] yv [3];
      logic             rv [3];
      yv[0] = 32'hFFFF_FFFF; rv[0] = 1'b0;
      yv[1] = 32'h0000_0000; rv[1] = 1'b1;
      yv[2] = 32'h8000_0000; rv[2] = 1'b0;
      ymode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         yconst = yv[k];
         send_frame(10 * k);
         wait_result(n);
         vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL thresh_%0d_m_valid: got %b want 1", k, bus.m_valid); end
         vectors++; if (bus.m_score !== yv[k]) begin miscompares++; $display("FAIL thresh_%0d_score: got %0h want %0h", k, bus.m_score, yv[k]); end
         vectors++; if (bus.m_real !== rv[k]) begin miscompares++; $display("FAIL thresh_%0d_real: got %b want %b", k, bus.m_real, rv[k]); end
         handshake();
      end
      ymode = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      send_frame(100);
      wait_result(n);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'd77;
      repeat (5) begin
         @(negedge clk);
         vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_m_valid: got %b want 1", bus.m_valid); end
         vectors++; if (bus.m_score !== 32'd936) begin miscompares++; $display("FAIL bp_score: got %0d want 936", bus.m_score); end
         vectors++; if (a_5 !== 32'd104) begin miscompares++; $display("FAIL bp_a_5: got %0d want 104", a_5); end
         vectors++; if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready: got %b want 0", bus.s_ready); end
      end
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b0;
      vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_s_ready: got %b want 1", bus.s_ready); end
      vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_m_valid: got %b want 0", bus.m_valid); end
      vectors++; if (bus.m_score !== 32'd936) begin miscompares++; $display("FAIL bp_score_retained: got %0d want 936", bus.m_score); end
   endtask

   task automatic test_short_frame();
      int n;
      beat(50, 1'b0);
      beat(51, 1'b0);
      beat(52, 1'b0);
      beat(53, 1'b1);
      vectors++; if (err_short !== 1'b1) begin miscompares++; $display("FAIL short_err_pulse: got %b want 1", err_short); end
      vectors++; if (frame_vld !== 1'b0) begin miscompares++; $display("FAIL short_frame_vld: got %b want 0", frame_vld); end
      vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL short_s_ready: got %b want 1", bus.s_ready); end
      vectors++; if (a_1 !== 32'd50 || a_4 !== 32'd53) begin miscompares++; $display("FAIL short_partial: got %0d,%0d want 50,53", a_1, a_4); end
      @(posedge clk); #1;
      vectors++; if (err_short !== 1'b0) begin miscompares++; $display("FAIL short_err_width: got %b want 0", err_short); end
      send_frame(1);
      wait_result(n);
      vectors++; if (bus.m_valid !== 1'b1 || bus.m_score !== 32'd45) begin miscompares++; $display("FAIL short_recover_score: got %b/%0d want 1/45", bus.m_valid, bus.m_score); end
      vectors++; if (a_1 !== 32'd1 || a_9 !== 32'd9) begin miscompares++; $display("FAIL short_recover_align: got %0d,%0d want 1,9", a_1, a_9); end
      handshake();
   endtask

   task automatic test_midop_reset();
      int n;
      send_frame(1);
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++; if (frame_vld !== 1'b0 || bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_settle_flags: got %b/%b want 0/0", frame_vld, bus.m_valid); end
      vectors++; if (a_1 !== 32'd0 || a_9 !== 32'd0) begin miscompares++; $display("FAIL rst_settle_frame: got %0d,%0d want 0,0", a_1, a_9); end
      vectors++; if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_settle_s_ready: got %b want 0", bus.s_ready); end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_settle_no_result: got %b want 0", bus.m_valid); end
      end
      vectors++; if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_settle_load: got %b want 1", bus.s_ready); end
      send_frame(1);
      wait_result(n);
      vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL rst_out_reached: got %b want 1", bus.m_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++; if (bus.m_valid !== 1'b0 || bus.m_score !== 32'd0 || bus.m_real !== 1'b0) begin miscompares++; $display("FAIL rst_out_result: got %b/%0d/%b want 0/0/0", bus.m_valid, bus.m_score, bus.m_real); end
      vectors++; if (frame_vld !== 1'b0 || bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_out_flags: got %b/%b want 0/0", frame_vld, bus.s_ready); end
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_load: got %b/%b want 1/0", bus.s_ready, bus.m_valid); end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      ymode       = 1'b0;
      yconst      = '0;
      test_reset();
      test_basic_frame();
      test_threshold();
      test_backpressure();
      test_short_frame();
      test_midop_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
